// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_pkg
// Brief   : Shared defaults and lane-count width helper for the FIFO read packer
// Revision: 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  localparam int c_DSIZE = 8;
  localparam int c_PACK  = 4;

  // Lane counts run 1..PACK, so the field must hold PACK itself.
  function automatic int lane_width(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_out_reg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_out_reg
// Brief   : Single-entry valid/ready holding register with load and accept
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rd_out_reg #(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [LANE_W-1:0] i_lanes,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_data,
  output logic [LANE_W-1:0] o_lanes,
  output logic              o_valid,
  output logic              o_free
);

  logic [WIDTH-1:0]  r_data;
  logic [LANE_W-1:0] r_lanes;
  logic              r_valid;

  // The caller only loads when o_free is high, so a load never drops a word.
  assign o_free = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_lanes <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_lanes <= i_lanes;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_lanes = r_lanes;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_packer
// Brief   : Pops FIFO words and packs PACK of them into one valid/ready beat
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE  = c_DSIZE,
  parameter int PACK   = c_PACK,
  localparam int LANE_W = lane_width(PACK)
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [DSIZE-1:0]      rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic [LANE_W-1:0]     out_lanes,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int              CNT_W  = $clog2(PACK);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PACK - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic                  r_flush_done;
  logic                  r_flush_ack;
  logic [DSIZE*PACK-1:0] w_acc;
  logic [DSIZE*PACK-1:0] w_full_word;
  logic [DSIZE*PACK-1:0] w_load_data;
  logic [LANE_W-1:0]     w_load_lanes;
  logic                  w_out_free;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_flush_go;
  logic                  w_flush_emit;
  logic                  w_beat_emit;
  logic                  w_load;
  logic                  w_acc_clr;

  assign w_last = (r_cnt == c_LAST);

  // Gating on rrst_n keeps the pop strobe quiet while reset is held.
  assign w_pop = rrst_n && !rempty && !flush && !(w_last && !w_out_free);
  assign rinc  = w_pop;

  // r_flush_ack blocks a second completion until the requester drops flush.
  assign w_flush_go   = flush && !r_flush_ack;
  assign w_flush_emit = w_flush_go && (r_cnt != '0) && w_out_free;
  assign w_beat_emit  = w_pop && w_last;
  assign w_load       = w_beat_emit || w_flush_emit;
  assign w_acc_clr    = w_load;

  assign w_full_word  = {rdata, w_acc[DSIZE*(PACK-1)-1:0]};
  assign w_load_data  = w_beat_emit ? w_full_word : w_acc;
  assign w_load_lanes = w_beat_emit ? LANE_W'(PACK) : LANE_W'(r_cnt);

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    localparam logic [CNT_W-1:0] c_IDX = CNT_W'(i);
    logic [DSIZE-1:0] r_lane;

    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        r_lane <= '0;
      end else if (w_acc_clr) begin
        r_lane <= '0;
      end else if (w_pop && (r_cnt == c_IDX)) begin
        r_lane <= rdata;
      end
    end

    assign w_acc[i*DSIZE +: DSIZE] = r_lane;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_cnt        <= '0;
      r_flush_done <= 1'b0;
      r_flush_ack  <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (!flush) begin
        r_flush_ack <= 1'b0;
      end
      if (w_pop) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end else if (w_flush_go) begin
        if (r_cnt == '0) begin
          r_flush_done <= 1'b1;
          r_flush_ack  <= 1'b1;
        end else if (w_out_free) begin
          r_cnt        <= '0;
          r_flush_done <= 1'b1;
          r_flush_ack  <= 1'b1;
        end
      end
    end
  end

  assign flush_done = r_flush_done;

  fifo_rd_out_reg #(
    .WIDTH  (DSIZE*PACK),
    .LANE_W (LANE_W)
  ) u_out_reg (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_lanes (w_load_lanes),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_lanes (out_lanes),
    .o_valid (out_valid),
    .o_free  (w_out_free)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rd_packer
// Brief   : Directed self-checking bench for fifo_rd_packer (DSIZE=8, PACK=4)
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        rempty = 1'b1;
  logic        rinc;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [31:0] out_data;
  logic [2:0]  out_lanes;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  logic [7:0] q[$];

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rdata      (rdata),
    .rempty     (rempty),
    .rinc       (rinc),
    .flush      (flush),
    .flush_done (flush_done),
    .out_data   (out_data),
    .out_lanes  (out_lanes),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic refresh();
    rempty = (q.size() == 0);
    rdata  = rempty ? 8'h00 : q[0];
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  // Inputs settle, the pop strobe is sampled, the FIFO model pops after the edge.
  task automatic tick();
    logic p;
    #1;
    p = rinc;
    @(posedge rclk);
    #1;
    if (p && q.size() > 0) begin
      void'(q.pop_front());
      n_pops++;
    end
    refresh();
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    q.delete();
    refresh();
    tick();
    tick();
    rrst_n = 1'b1;
    n_pops = 0;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    push(8'h99);
    tick();
    #1;
    n_checks++;
    if (rinc !== 1'b0) begin n_errors++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_lanes !== 3'd0 || flush_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b data=%h lanes=%0d done=%b want 0", out_valid, out_data, out_lanes, flush_done);
    end
    @(negedge rclk);
    n_pops = 0;
    rrst_n = 1'b1;
    #1;
    n_checks++;
    if (rinc !== 1'b1) begin n_errors++; $display("FAIL reset_release_rinc: got %b want 1", rinc); end
    tick();
    n_checks++;
    if (n_pops !== 1) begin n_errors++; $display("FAIL reset_first_pop: pops %0d want 1", n_pops); end
  endtask

  task automatic test_full_beat();
    int vcycles;
    logic [31:0] seen;
    logic [2:0]  seen_lanes;
    do_reset();
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    vcycles = 0;
    seen = '0;
    seen_lanes = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        vcycles++;
        seen = out_data;
        seen_lanes = out_lanes;
      end
      tick();
      if (i == 3) begin
        n_checks++;
        if (n_pops !== 4) begin n_errors++; $display("FAIL full_consecutive_pops: pops %0d want 4", n_pops); end
      end
    end
    n_checks++;
    if (seen !== 32'h44332211) begin n_errors++; $display("FAIL full_data: got %h want 44332211", seen); end
    n_checks++;
    if (seen_lanes !== 3'd4) begin n_errors++; $display("FAIL full_lanes: got %0d want 4", seen_lanes); end
    n_checks++;
    if (vcycles !== 1) begin n_errors++; $display("FAIL full_valid_cycles: got %0d want 1", vcycles); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
      n_errors++;
      $display("FAIL bp_hold: valid=%b data=%h want 1 04030201", out_valid, out_data);
    end
    n_checks++;
    if (n_pops !== 7) begin n_errors++; $display("FAIL bp_pops: got %0d want 7", n_pops); end
    #1;
    n_checks++;
    if (rinc !== 1'b0) begin n_errors++; $display("FAIL bp_stall_rinc: got %b want 0", rinc); end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (rinc !== 1'b1) begin n_errors++; $display("FAIL bp_release_rinc: got %b want 1", rinc); end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h08070605 || out_lanes !== 3'd4) begin
      n_errors++;
      $display("FAIL bp_second_word: valid=%b data=%h lanes=%0d want 1 08070605 4", out_valid, out_data, out_lanes);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain: valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int pulses;
    do_reset();
    out_ready = 1'b1;
    push(8'hAA); push(8'hBB); push(8'hCC);
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00CCBBAA || out_lanes !== 3'd3) begin
      n_errors++;
      $display("FAIL flush_partial: valid=%b data=%h lanes=%0d want 1 00ccbbaa 3", out_valid, out_data, out_lanes);
    end
    n_checks++;
    if (flush_done !== 1'b1) begin n_errors++; $display("FAIL flush_done_pulse: got %b want 1", flush_done); end
    flush = 1'b0;
    tick();
    n_checks++;
    if (flush_done !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_after: done=%b valid=%b want 0 0", flush_done, out_valid);
    end
    // Empty flush held high for several cycles: one pulse, no beat.
    flush = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (flush_done) pulses++;
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_empty_valid: got %b want 0", out_valid); end
    end
    flush = 1'b0;
    n_checks++;
    if (pulses !== 1) begin n_errors++; $display("FAIL flush_empty_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_mid_reset();
    int waited;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (out_valid !== 1'b1 || n_pops !== 6) begin
      n_errors++;
      $display("FAIL mid_setup: valid=%b pops=%0d want 1 6", out_valid, n_pops);
    end
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_lanes !== 3'd0) begin
      n_errors++;
      $display("FAIL mid_reset_clear: valid=%b data=%h lanes=%0d want 0", out_valid, out_data, out_lanes);
    end
    tick();
    rrst_n = 1'b1;
    out_ready = 1'b1;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!out_valid) begin
      n_errors++;
      $display("FAIL mid_timeout: no beat after %0d cycles", waited);
    end else if (out_data !== 32'h88776655 || out_lanes !== 3'd4) begin
      n_errors++;
      $display("FAIL mid_word: data=%h lanes=%0d want 88776655 4", out_data, out_lanes);
    end
  endtask

  task automatic test_stream();
    logic [7:0]  src [32];
    logic [31:0] exp_word;
    int pushed, beats, cycles;
    do_reset();
    for (int i = 0; i < 32; i++) src[i] = 8'($urandom_range(0, 255));
    pushed = 0;
    beats = 0;
    cycles = 0;
    while (beats < 8 && cycles < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        exp_word = {src[4*beats+3], src[4*beats+2], src[4*beats+1], src[4*beats]};
        n_checks++;
        if (out_data !== exp_word || out_lanes !== 3'd4) begin
          n_errors++;
          $display("FAIL stream_beat%0d: data=%h lanes=%0d want %h 4", beats, out_data, out_lanes, exp_word);
        end
        beats++;
      end
      if (pushed < 32 && q.size() < 8 && $urandom_range(0, 2) != 0) begin
        push(src[pushed]);
        pushed++;
      end
      tick();
      cycles++;
    end
    n_checks++;
    if (beats !== 8 || n_pops !== 32 || q.size() !== 0) begin
      n_errors++;
      $display("FAIL stream_totals: beats=%0d pops=%0d left=%0d want 8 32 0", beats, n_pops, q.size());
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_extra_beat: valid=%b want 0", out_valid); end
  endtask

  initial begin
    #2;
    @(negedge rclk);
    test_reset();
    test_full_beat();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
